// File: rtl/hazard_forward_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit_pkg
//
// Shared definitions for the hazard/forwarding unit of the 5-stage RV32I
// pipeline:
//   - REG_W / SEL_W       : register index width and operand-select width
//   - fwd_sel_e           : operand-select codes for the EX operand muxes
//                           (FWD_REGFILE = 0, FWD_EXMEM = 1, FWD_MEMWB = 2,
//                            FWD_WBHOLD = 3)
//   - stage_t             : shadow record kept for each of EX, MEM and WB
//   - pick_fwd()          : youngest-match-wins priority encoder
// -----------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        FWD_REGFILE = 2'd0,
        FWD_EXMEM   = 2'd1,
        FWD_MEMWB   = 2'd2,
        FWD_WBHOLD  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

    // The youngest producer holds the most recent value of the register,
    // so EX beats MEM beats WB.
    function automatic fwd_sel_e pick_fwd(input logic ex_hit,
                                          input logic mem_hit,
                                          input logic wb_hit);
        fwd_sel_e sel;
        sel = FWD_REGFILE;
        if (ex_hit) begin
            sel = FWD_EXMEM;
        end else if (mem_hit) begin
            sel = FWD_MEMWB;
        end else if (wb_hit) begin
            sel = FWD_WBHOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_forward_unit_match.sv
// -----------------------------------------------------------------------------
// hazard_match
//
// Combinational compare of one shadow pipeline stage against one source
// register of the instruction in ID.
//
// Ports:
//   stage_valid     in  1  shadow stage holds a real instruction
//   stage_rd        in  5  destination register of that instruction
//   stage_reg_write in  1  that instruction writes its destination
//   rs              in  5  source register index from ID
//   rs_used         in  1  ID instruction really reads rs
//   hit             out 1  stage will produce the value rs needs
// -----------------------------------------------------------------------------
module hazard_match
    import hazard_forward_unit_pkg::*;
(
    input  logic             stage_valid,
    input  logic [REG_W-1:0] stage_rd,
    input  logic             stage_reg_write,
    input  logic [REG_W-1:0] rs,
    input  logic             rs_used,
    output logic             hit
);

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    assign hit = stage_valid && stage_reg_write && rs_used &&
                 (rs != '0) && (stage_rd == rs);

endmodule

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard tracking for the 5-stage RV32I pipeline. Keeps shadow copies of the
// destination info of the instructions in EX, MEM and WB, and from those
// produces the registered ALU operand-select codes for EX plus the load-use
// stall and bubble controls.
//
// Build option: macro FORWARDING_EN
//   defined   : operands are forwarded; only a load-use hazard stalls.
//   undefined : selects are tied to 0 and ID stalls while any in-flight
//               instruction writes one of its sources.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs1, id_rs2            ID source registers
//   id_rs1_used, id_rs2_used  the source is actually read
//   id_rd, id_reg_write       ID destination and its write enable
//   id_mem_read               ID instruction is a load
//   flush                     kill the instruction in ID
//   fwd_a_sel, fwd_b_sel      registered operand selects for EX
//   stall                     combinational: hold PC and IF/ID
//   bubble                    registered: EX holds an inserted NOP
// -----------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel,
    output logic             stall,
    output logic             bubble
);

    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;
    stage_t wb_q, wb_d;
    logic   bubble_q, bubble_d;

    // A source only matters when ID really holds an instruction.
    logic rs1_live, rs2_live;
    assign rs1_live = id_valid && id_rs1_used;
    assign rs2_live = id_valid && id_rs2_used;

    logic ex_hit_a, mem_hit_a, wb_hit_a;
    logic ex_hit_b, mem_hit_b, wb_hit_b;

    hazard_match u_ex_a (
        .stage_valid     (ex_q.valid),
        .stage_rd        (ex_q.rd),
        .stage_reg_write (ex_q.reg_write),
        .rs              (id_rs1),
        .rs_used         (rs1_live),
        .hit             (ex_hit_a)
    );

    hazard_match u_mem_a (
        .stage_valid     (mem_q.valid),
        .stage_rd        (mem_q.rd),
        .stage_reg_write (mem_q.reg_write),
        .rs              (id_rs1),
        .rs_used         (rs1_live),
        .hit             (mem_hit_a)
    );

    hazard_match u_wb_a (
        .stage_valid     (wb_q.valid),
        .stage_rd        (wb_q.rd),
        .stage_reg_write (wb_q.reg_write),
        .rs              (id_rs1),
        .rs_used         (rs1_live),
        .hit             (wb_hit_a)
    );

    hazard_match u_ex_b (
        .stage_valid     (ex_q.valid),
        .stage_rd        (ex_q.rd),
        .stage_reg_write (ex_q.reg_write),
        .rs              (id_rs2),
        .rs_used         (rs2_live),
        .hit             (ex_hit_b)
    );

    hazard_match u_mem_b (
        .stage_valid     (mem_q.valid),
        .stage_rd        (mem_q.rd),
        .stage_reg_write (mem_q.reg_write),
        .rs              (id_rs2),
        .rs_used         (rs2_live),
        .hit             (mem_hit_b)
    );

    hazard_match u_wb_b (
        .stage_valid     (wb_q.valid),
        .stage_rd        (wb_q.rd),
        .stage_reg_write (wb_q.reg_write),
        .rs              (id_rs2),
        .rs_used         (rs2_live),
        .hit             (wb_hit_b)
    );

    // Nothing downstream of WB needs the load flag; the record keeps it so
    // every shadow stage has the same shape.
    logic wb_mem_read_unused;
    assign wb_mem_read_unused = wb_q.mem_read;

`ifdef FORWARDING_EN
    // Only a load sitting in EX cannot be forwarded in time: its data
    // arrives at the end of MEM. One stall moves it to MEM, where the
    // MEM/WB path covers it.
    logic load_use;
    assign load_use = ex_q.mem_read && (ex_hit_a || ex_hit_b);
    assign stall    = load_use && !flush;
`else
    // Without forwarding the reader has to wait until every in-flight
    // producer has left WB.
    assign stall = (ex_hit_a || mem_hit_a || wb_hit_a ||
                    ex_hit_b || mem_hit_b || wb_hit_b) && !flush;
`endif

    // Shadow pipeline advance. A stalled or flushed ID instruction is
    // replaced by an invalid record, which is the bubble seen in EX.
    always_comb begin
        ex_d     = STAGE_EMPTY;
        mem_d    = ex_q;
        wb_d     = mem_q;
        bubble_d = stall || flush;
        if (id_valid && !stall && !flush) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= STAGE_EMPTY;
            mem_q    <= STAGE_EMPTY;
            wb_q     <= STAGE_EMPTY;
            bubble_q <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            bubble_q <= bubble_d;
        end
    end

    assign bubble = bubble_q;

`ifdef FORWARDING_EN
    logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0] fwd_b_q, fwd_b_d;

    // Selects are decided against the pre-edge shadows so they line up
    // with the instruction entering EX. A stalled or flushed ID puts a
    // bubble in EX, which must read the register file.
    always_comb begin
        fwd_a_d = FWD_REGFILE;
        fwd_b_d = FWD_REGFILE;
        if (!stall && !flush) begin
            fwd_a_d = pick_fwd(ex_hit_a, mem_hit_a, wb_hit_a);
            fwd_b_d = pick_fwd(ex_hit_b, mem_hit_b, wb_hit_b);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
`else
    assign fwd_a_sel = FWD_REGFILE;
    assign fwd_b_sel = FWD_REGFILE;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Drives instruction sequences into ID one cycle at a time. For each cycle
// the expected stall is checked before the edge, and the expected
// {fwd_a_sel, fwd_b_sel, bubble} is queued and checked just after the edge.
// Expectations follow whichever FORWARDING_EN build is compiled.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       bubble;

    int total = 0;
    int bad   = 0;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    hazard_forward_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .bubble       (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One ID cycle: the instruction presented, the stall expected during
    // that cycle, and {a_sel, b_sel, bubble} expected after the edge.
    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       st;
        logic [4:0] outs;
    } row_t;

    logic [4:0] sb[$];

    function automatic row_t mk(input int rs1, input int u1, input int rs2,
                                input int u2, input int rd, input int rw,
                                input int mr, input int fl, input int st,
                                input int a, input int b, input int bub);
        row_t r;
        r.v    = 1'b1;
        r.rs1  = 5'(rs1);
        r.u1   = 1'(u1);
        r.rs2  = 5'(rs2);
        r.u2   = 1'(u2);
        r.rd   = 5'(rd);
        r.rw   = 1'(rw);
        r.mr   = 1'(mr);
        r.fl   = 1'(fl);
        r.st   = 1'(st);
        r.outs = {2'(a), 2'(b), 1'(bub)};
        return r;
    endfunction

    function automatic row_t nop();
        row_t r;
        r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        r.v = 1'b0;
        return r;
    endfunction

    task automatic apply_row(input row_t r);
        id_valid     = r.v;
        id_rs1       = r.rs1;
        id_rs1_used  = r.u1;
        id_rs2       = r.rs2;
        id_rs2_used  = r.u2;
        id_rd        = r.rd;
        id_reg_write = r.rw;
        id_mem_read  = r.mr;
        flush        = r.fl;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b1;
        apply_row(mk(7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        got = {fwd_a_sel, fwd_b_sel, bubble};
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_stall got=%0b want=0", stall);
        end
        total++;
        if (got !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL reset_outs got=%b want=00000", got);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [4:0] exp;
        rows.push_back(mk(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        if (FWD) begin
            rows.push_back(mk(5, 1, 1, 1, 6, 1, 0, 0, 0, 1, 0, 0));
        end else begin
            for (int k = 0; k < 3; k++)
                rows.push_back(mk(5, 1, 1, 1, 6, 1, 0, 0, 1, 0, 0, 1));
            rows.push_back(mk(5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0));
        end
        for (int k = 0; k < 3; k++) rows.push_back(nop());
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            total++;
            if (stall !== rows[i].st) begin
                bad++;
                $display("[TB] FAIL b2b[%0d] stall got=%0b want=%0b", i, stall, rows[i].st);
            end
            sb.push_back(rows[i].outs);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            total++;
            if ({fwd_a_sel, fwd_b_sel, bubble} !== exp) begin
                bad++;
                $display("[TB] FAIL b2b[%0d] a,b,bub got=%b want=%b", i, {fwd_a_sel, fwd_b_sel, bubble}, exp);
            end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic [4:0] exp;
        rows.push_back(mk(1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(7, 1, 7, 1, 8, 1, 0, 0, 1, 0, 0, 1));
        if (FWD) begin
            rows.push_back(mk(7, 1, 7, 1, 8, 1, 0, 0, 0, 2, 2, 0));
        end else begin
            rows.push_back(mk(7, 1, 7, 1, 8, 1, 0, 0, 1, 0, 0, 1));
            rows.push_back(mk(7, 1, 7, 1, 8, 1, 0, 0, 1, 0, 0, 1));
            rows.push_back(mk(7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0));
        end
        for (int k = 0; k < 3; k++) rows.push_back(nop());
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            total++;
            if (stall !== rows[i].st) begin
                bad++;
                $display("[TB] FAIL load_use[%0d] stall got=%0b want=%0b", i, stall, rows[i].st);
            end
            sb.push_back(rows[i].outs);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            total++;
            if ({fwd_a_sel, fwd_b_sel, bubble} !== exp) begin
                bad++;
                $display("[TB] FAIL load_use[%0d] a,b,bub got=%b want=%b", i, {fwd_a_sel, fwd_b_sel, bubble}, exp);
            end
        end
    endtask

    task automatic test_distance();
        row_t rows[$];
        logic [4:0] exp;
        // producer of x9, two independent instructions, then a reader
        rows.push_back(mk(1, 1, 2, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 2, 1, 10, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 2, 1, 11, 1, 0, 0, 0, 0, 0, 0));
        if (FWD) begin
            rows.push_back(mk(9, 1, 3, 1, 12, 1, 0, 0, 0, 3, 0, 0));
            // distance two on rs1, distance one on rs2
            rows.push_back(mk(1, 1, 2, 1, 13, 1, 0, 0, 0, 0, 0, 0));
            rows.push_back(mk(1, 1, 2, 1, 14, 1, 0, 0, 0, 0, 0, 0));
            rows.push_back(mk(13, 1, 14, 1, 15, 1, 0, 0, 0, 2, 1, 0));
            // x14 rewritten: the younger copy in EX wins over the one in WB
            rows.push_back(mk(1, 1, 2, 1, 14, 1, 0, 0, 0, 0, 0, 0));
            rows.push_back(mk(14, 1, 14, 1, 16, 1, 0, 0, 0, 1, 1, 0));
        end else begin
            rows.push_back(mk(9, 1, 3, 1, 12, 1, 0, 0, 1, 0, 0, 1));
            rows.push_back(mk(9, 1, 3, 1, 12, 1, 0, 0, 0, 0, 0, 0));
        end
        // a gap of four leaves the producer out of the shadow stages
        rows.push_back(mk(1, 1, 2, 1, 17, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            rows.push_back(mk(1, 1, 2, 1, 18 + k, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(17, 1, 3, 1, 22, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) rows.push_back(nop());
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            total++;
            if (stall !== rows[i].st) begin
                bad++;
                $display("[TB] FAIL distance[%0d] stall got=%0b want=%0b", i, stall, rows[i].st);
            end
            sb.push_back(rows[i].outs);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            total++;
            if ({fwd_a_sel, fwd_b_sel, bubble} !== exp) begin
                bad++;
                $display("[TB] FAIL distance[%0d] a,b,bub got=%b want=%b", i, {fwd_a_sel, fwd_b_sel, bubble}, exp);
            end
        end
    endtask

    task automatic test_x0();
        row_t rows[$];
        logic [4:0] exp;
        rows.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) rows.push_back(nop());
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            total++;
            if (stall !== rows[i].st) begin
                bad++;
                $display("[TB] FAIL x0[%0d] stall got=%0b want=%0b", i, stall, rows[i].st);
            end
            sb.push_back(rows[i].outs);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            total++;
            if ({fwd_a_sel, fwd_b_sel, bubble} !== exp) begin
                bad++;
                $display("[TB] FAIL x0[%0d] a,b,bub got=%b want=%b", i, {fwd_a_sel, fwd_b_sel, bubble}, exp);
            end
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        logic [4:0] exp;
        rows.push_back(mk(1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
        // dependent on the load but flushed: no stall, bubble follows
        rows.push_back(mk(7, 1, 7, 1, 8, 1, 0, 1, 0, 0, 0, 1));
        // reader of x8 proves the killed instruction never reached EX
        rows.push_back(mk(8, 1, 3, 1, 9, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) rows.push_back(nop());
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            total++;
            if (stall !== rows[i].st) begin
                bad++;
                $display("[TB] FAIL flush[%0d] stall got=%0b want=%0b", i, stall, rows[i].st);
            end
            sb.push_back(rows[i].outs);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            total++;
            if ({fwd_a_sel, fwd_b_sel, bubble} !== exp) begin
                bad++;
                $display("[TB] FAIL flush[%0d] a,b,bub got=%b want=%b", i, {fwd_a_sel, fwd_b_sel, bubble}, exp);
            end
        end
    endtask

    task automatic test_operands();
        row_t rows[$];
        logic [4:0] exp;
        rows.push_back(mk(1, 1, 2, 1, 20, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 2, 1, 21, 1, 0, 0, 0, 0, 0, 0));
        if (FWD) begin
            rows.push_back(mk(21, 1, 20, 1, 22, 1, 0, 0, 0, 1, 2, 0));
        end else begin
            for (int k = 0; k < 3; k++)
                rows.push_back(mk(21, 1, 20, 1, 22, 1, 0, 0, 1, 0, 0, 1));
            rows.push_back(mk(21, 1, 20, 1, 22, 1, 0, 0, 0, 0, 0, 0));
        end
        // same registers named but not read
        rows.push_back(mk(21, 0, 20, 0, 23, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 0, 24, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(3, 1, 24, 0, 25, 1, 0, 0, 0, 0, 0, 0));
        if (FWD) begin
            rows.push_back(mk(3, 1, 24, 1, 26, 1, 0, 0, 0, 0, 2, 0));
        end else begin
            rows.push_back(mk(3, 1, 24, 1, 26, 1, 0, 0, 1, 0, 0, 1));
            rows.push_back(mk(3, 1, 24, 1, 26, 1, 0, 0, 1, 0, 0, 1));
            rows.push_back(mk(3, 1, 24, 1, 26, 1, 0, 0, 0, 0, 0, 0));
        end
        for (int k = 0; k < 3; k++) rows.push_back(nop());
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            total++;
            if (stall !== rows[i].st) begin
                bad++;
                $display("[TB] FAIL operands[%0d] stall got=%0b want=%0b", i, stall, rows[i].st);
            end
            sb.push_back(rows[i].outs);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            total++;
            if ({fwd_a_sel, fwd_b_sel, bubble} !== exp) begin
                bad++;
                $display("[TB] FAIL operands[%0d] a,b,bub got=%b want=%b", i, {fwd_a_sel, fwd_b_sel, bubble}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        row_t rows[$];
        logic [4:0] exp;
        logic [4:0] live_outs;
        rows.push_back(mk(1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0));
        if (FWD)
            rows.push_back(mk(5, 1, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0));
        else
            rows.push_back(mk(5, 1, 0, 0, 7, 1, 1, 0, 1, 0, 0, 1));
        foreach (rows[i]) begin
            apply_row(rows[i]);
            @(negedge clk);
            total++;
            if (stall !== rows[i].st) begin
                bad++;
                $display("[TB] FAIL rst_mid[%0d] stall got=%0b want=%0b", i, stall, rows[i].st);
            end
            sb.push_back(rows[i].outs);
            @(posedge clk);
            #1;
            exp = sb.pop_front();
            total++;
            if ({fwd_a_sel, fwd_b_sel, bubble} !== exp) begin
                bad++;
                $display("[TB] FAIL rst_mid[%0d] a,b,bub got=%b want=%b", i, {fwd_a_sel, fwd_b_sel, bubble}, exp);
            end
        end
        // Live hazard: forwarding build sees load-use on x7, the other
        // build still waits on x5 (held lw now sees the producer in MEM).
        if (FWD)
            apply_row(mk(7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0));
        else
            apply_row(mk(5, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_mid_live stall got=%0b want=1", stall);
        end
        rst = 1'b1;
        #1;
        live_outs = {fwd_a_sel, fwd_b_sel, bubble};
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_stall got=%0b want=0", stall);
        end
        total++;
        if (live_outs !== 5'b00000) begin
            bad++;
            $display("[TB] FAIL rst_mid_outs got=%b want=00000", live_outs);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        // first instruction after reset sees no hazards
        apply_row(mk(7, 1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_rst_stall got=%0b want=0", stall);
        end
        sb.push_back(5'b00000);
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        total++;
        if ({fwd_a_sel, fwd_b_sel, bubble} !== exp) begin
            bad++;
            $display("[TB] FAIL post_rst_outs got=%b want=%b", {fwd_a_sel, fwd_b_sel, bubble}, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        apply_row(nop());
        test_reset();
        test_back_to_back();
        test_load_use();
        test_distance();
        test_x0();
        test_flush();
        test_operands();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
